display_port_controller: RTL
============================

// Module: display_port_controller
// PURPOSE
//  Sequences all writes into the character display (dsp) on behalf of the PicoBlaze.
//  - Decodes a small port-I/O register window: cursor row/col, attribute, char, command.
//  - Auto-advances the cursor, interprets newline, and runs a full-screen clear engine.
//  - Owns the dsp write port exclusively; issues at most one cell write per cycle.
// PARAMETERS
//  BASE_PORT     8'h80  port_id of register 0; window is BASE_PORT..BASE_PORT+4
//  COLS          80     visible columns (1..128)
//  ROWS          30     visible rows (1..32)
//  CLEAR_CHAR    8'h20  character written by the clear engine
//  DEFAULT_ATTR  8'h0F  attribute register reset value
// PORTS
//  clk           in   1   system clock
//  reset         in   1   synchronous, active-high reset
//  port_id       in   8   CPU port address
//  write_strobe  in   1   CPU write strobe, 1 cycle
//  out_port      in   8   CPU write data
//  read_data     out  8   CPU read data, registered
//  dsp_row       out  5   display cell row
//  dsp_col       out  7   display cell column
//  dsp_en        out  1   display cell access strobe
//  dsp_wr        out  1   display write enable (high whenever dsp_en is high)
//  dsp_wr_data   out  16  {attribute[7:0], char[7:0]}
//  busy          out  1   clear engine active
// BEHAVIOUR
//  Reset values
//  - row=0, col=0, attr=DEFAULT_ATTR, FSM=IDLE.
//  - dsp_en=0, dsp_wr=0, dsp_row=0, dsp_col=0, dsp_wr_data=0, busy=0, read_data=0.
//  Register window (write_strobe && port_id==BASE_PORT+n)
//  - n=0: row<=out_port[4:0]; value >= ROWS loads ROWS-1.
//  - n=1: col<=out_port[6:0]; value >= COLS loads COLS-1.
//  - n=2: attr<=out_port.
//  - n=3: char write.
//  - n=4: bit0=1 starts clear; other bits ignored.
//  - Other port_ids: ignored.
//  Char write
//  - out_port!=8'h0A: cycle after strobe, dsp_en=1 with {row,col} and {attr,out_port};
//    then col++. At col==COLS-1: col<=0, row++. At row==ROWS-1: row<=0.
//  - out_port==8'h0A: no dsp access; col<=0, row++ with the same row wrap.
//  - Back-to-back strobes: one dsp write per strobe, each 1 cycle after its strobe.
//  FSM IDLE/CLEAR
//  - IDLE->CLEAR on a clear command: busy=1 from the next cycle.
//  - CLEAR writes {attr,CLEAR_CHAR} to every cell, row-major from (0,0), one cell per cycle.
//  - The dsp_en burst starts the cycle after the command and spans ROWS*COLS consecutive cycles.
//  - After cell (ROWS-1,COLS-1): ->IDLE, busy=0, row=col=0.
//  - attr is sampled at command time; later attr writes do not affect an ongoing clear.
//  Busy interactions
//  - While busy: char, row, col and clear writes are dropped, with no state change.
//  - attr writes are accepted while busy.
//  - A clear command in IDLE in the same cycle as nothing else: no conflict is possible,
//    since the CPU issues one strobe per cycle.
//  Reads
//  - read_data updates every cycle from port_id.
//  - +0 -> {3'b0,row}; +1 -> {1'b0,col}; +2 -> attr; +4 -> {7'b0,busy}; others -> 8'h00.
//  Reset
//  - reset mid-clear aborts immediately: dsp_en=0 the next cycle and all regs at reset values.
// TESTING
//  1. Reset; write 8'h41 to +3.
//     -> next cycle dsp_en=1, row=0, col=0, data=16'h0F41; col reads back 1.
//  2. row=0, col=79; write 'X' then 'Y'.
//     -> 'X' at (0,79), 'Y' at (1,0).
//  3. row=29, col=79; write 'Z'; also row=5, col=10, write 8'h0A.
//     -> cursor (0,0) after 'Z'; (6,0) after newline with no dsp_en.
//  4. attr=8'h1E; write 1 to +4.
//     -> exactly 2400 consecutive dsp_en cycles with data 16'h1E20 covering all cells;
//        busy high throughout; char writes during busy produce no dsp_en.
//  5. Assert reset 100 cycles into a clear.
//     -> dsp_en=0 from the next cycle; busy=0; row=col=0; attr=8'h0F.
//  6. Write 40 to +0 and 127 to +1.
//     -> reads give row=29, col=79.

Source files
------------

// File: rtl/display_port_controller.sv
// display_port_controller
//   Single writer of the character display on behalf of the PicoBlaze. It decodes
//   a five-register port window (row, col, attr, char, command) and keeps a cursor
//   that advances after each character and follows newlines. It also runs a
//   full-screen clear engine that writes one cell per cycle.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | CPU writes accepted; char writes go out one cycle after strobe
//   CLEAR  | sweeping every cell row-major; cursor/char/clear writes dropped
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_port_id               CPU port address
//   i_write_strobe          CPU write strobe, 1 cycle
//   i_out_port              CPU write data
//   o_read_data             registered CPU read data
//   o_dsp_row, o_dsp_col    display cell address
//   o_dsp_en, o_dsp_wr      display cell strobe / write enable (always equal)
//   o_dsp_wr_data           {attribute, char}
//   o_busy                  clear engine active
module display_port_controller #(
    parameter logic [7:0] BASE_PORT    = 8'h80,
    parameter int         COLS         = 80,
    parameter int         ROWS         = 30,
    parameter logic [7:0] CLEAR_CHAR   = 8'h20,
    parameter logic [7:0] DEFAULT_ATTR = 8'h0F
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_port_id,
    input  logic        i_write_strobe,
    input  logic [7:0]  i_out_port,
    output logic [7:0]  o_read_data,
    output logic [4:0]  o_dsp_row,
    output logic [6:0]  o_dsp_col,
    output logic        o_dsp_en,
    output logic        o_dsp_wr,
    output logic [15:0] o_dsp_wr_data,
    output logic        o_busy
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);
    localparam logic [6:0] COL_MAX = 7'(COLS - 1);
    localparam logic [8:0] ROWS_W  = 9'(ROWS);
    localparam logic [8:0] COLS_W  = 9'(COLS);

    logic [0:0]  r_state;
    logic [4:0]  r_row;
    logic [6:0]  r_col;
    logic [7:0]  r_attr;
    logic [7:0]  r_clr_attr;
    logic [4:0]  r_clr_row;
    logic [6:0]  r_clr_col;
    logic        r_wr_en;
    logic [4:0]  r_wr_row;
    logic [6:0]  r_wr_col;
    logic [15:0] r_wr_data;
    logic [7:0]  r_read_data;

    logic [7:0]  w_offset;
    logic        w_in_window;
    logic        w_busy;
    logic [4:0]  w_row_inc;
    logic [4:0]  w_row_clamp;
    logic [6:0]  w_col_clamp;
    logic        w_clr_last;
    logic [7:0]  w_read_mux;

    assign w_offset    = i_port_id - BASE_PORT;
    assign w_in_window = (w_offset < 8'd5);
    assign w_busy      = (r_state == S_CLEAR);
    assign w_row_inc   = (r_row == ROW_MAX) ? 5'd0 : r_row + 5'd1;
    // Clamp compares the whole byte so e.g. 40 clamps instead of aliasing to 8.
    assign w_row_clamp = ({1'b0, i_out_port} >= ROWS_W) ? ROW_MAX : i_out_port[4:0];
    assign w_col_clamp = ({1'b0, i_out_port} >= COLS_W) ? COL_MAX : i_out_port[6:0];
    assign w_clr_last  = (r_clr_row == ROW_MAX) && (r_clr_col == COL_MAX);

    always_comb begin
        w_read_mux = 8'h00;
        if (w_in_window) begin
            case (w_offset[2:0])
                3'd0:    w_read_mux = {3'b000, r_row};
                3'd1:    w_read_mux = {1'b0, r_col};
                3'd2:    w_read_mux = r_attr;
                3'd4:    w_read_mux = {7'b0000000, w_busy};
                default: w_read_mux = 8'h00;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_row       <= 5'd0;
            r_col       <= 7'd0;
            r_attr      <= DEFAULT_ATTR;
            r_clr_attr  <= 8'h00;
            r_clr_row   <= 5'd0;
            r_clr_col   <= 7'd0;
            r_wr_en     <= 1'b0;
            r_wr_row    <= 5'd0;
            r_wr_col    <= 7'd0;
            r_wr_data   <= 16'h0000;
            r_read_data <= 8'h00;
        end else begin
            r_wr_en     <= 1'b0;
            r_read_data <= w_read_mux;

            if (w_busy) begin
                if (w_clr_last) begin
                    r_state   <= S_IDLE;
                    r_clr_row <= 5'd0;
                    r_clr_col <= 7'd0;
                    r_row     <= 5'd0;
                    r_col     <= 7'd0;
                end else if (r_clr_col == COL_MAX) begin
                    r_clr_col <= 7'd0;
                    r_clr_row <= r_clr_row + 5'd1;
                end else begin
                    r_clr_col <= r_clr_col + 7'd1;
                end
            end

            if (i_write_strobe && w_in_window) begin
                case (w_offset[2:0])
                    3'd0: if (!w_busy) r_row <= w_row_clamp;
                    3'd1: if (!w_busy) r_col <= w_col_clamp;
                    3'd2: r_attr <= i_out_port;
                    3'd3: begin
                        if (!w_busy) begin
                            if (i_out_port == 8'h0A) begin
                                r_col <= 7'd0;
                                r_row <= w_row_inc;
                            end else begin
                                r_wr_en   <= 1'b1;
                                r_wr_row  <= r_row;
                                r_wr_col  <= r_col;
                                r_wr_data <= {r_attr, i_out_port};
                                if (r_col == COL_MAX) begin
                                    r_col <= 7'd0;
                                    r_row <= w_row_inc;
                                end else begin
                                    r_col <= r_col + 7'd1;
                                end
                            end
                        end
                    end
                    3'd4: begin
                        if (!w_busy && i_out_port[0]) begin
                            r_state    <= S_CLEAR;
                            r_clr_attr <= r_attr;
                            r_clr_row  <= 5'd0;
                            r_clr_col  <= 7'd0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // The clear sweep drives the port straight from its counters so the burst
    // lines up exactly with busy; char writes never overlap it because they
    // are dropped while busy.
    assign o_dsp_en      = w_busy | r_wr_en;
    assign o_dsp_wr      = o_dsp_en;
    assign o_dsp_row     = w_busy ? r_clr_row : r_wr_row;
    assign o_dsp_col     = w_busy ? r_clr_col : r_wr_col;
    assign o_dsp_wr_data = w_busy ? {r_clr_attr, CLEAR_CHAR} : r_wr_data;
    assign o_busy        = w_busy;
    assign o_read_data   = r_read_data;

endmodule
